qpi_gearbox_4x: RTL and testbench

//  Portable 4:1 QSPI gearbox between the 1x-domain PSRAM controller PHY interface and the pads.

---
 rtl/qpi_gearbox_4x.sv | 142 ++++++++++++++
 tb/tb_qpi_gearbox_4x.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpi_gearbox_4x.sv
`default_nettype none
// ============================================================================
// Module   : qpi_gearbox_4x
// Purpose  : 4:1 QSPI pad gearbox: serializes one 1x-period PHY word onto
//            4x-rate pads, deserializes pad nibbles back, monitors sync cadence.
// Revision : 1.0 - initial release
// ============================================================================
module qpi_gearbox_4x #(
    parameter int   RD_DELAY = 4,
    parameter logic IDLE_CLK = 1'b0
) (
    input  logic        clk_4x_s,
    input  logic        rst,
    input  logic        sync_4x,
    input  logic [15:0] phy_io_o,
    input  logic [3:0]  phy_io_oe,
    input  logic [3:0]  phy_clk_o,
    input  logic        phy_cs_o,
    output logic [15:0] phy_io_i,
    output logic [3:0]  pad_io_o,
    output logic        pad_io_oe,
    input  logic [3:0]  pad_io_i,
    output logic        pad_clk,
    output logic        pad_cs_n,
    output logic        locked,
    output logic        sync_err
);

    localparam logic [0:0] ST_UNLOCK = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]  state;
    logic [1:0]  phase;

    // Slot 0 goes straight from the PHY inputs on the load edge, so only
    // slots 1..3 need holding.
    logic [11:0] hold_io;
    logic [2:0]  hold_oe;
    logic [2:0]  hold_clk;
    logic        hold_cs;

    // Only taps up to RD_DELAY are ever observed.
    logic [3:0]  rx_pipe [0:RD_DELAY];
    logic [15:0] rx_asm;

    logic        load_edge;
    logic        cad_err;
    logic [1:0]  next_phase;
    logic [3:0]  next_nib;
    logic        next_oe;
    logic        next_clk;

    assign load_edge  = (state == ST_LOCKED) && sync_4x && (phase == 2'd3);
    assign cad_err    = (state == ST_LOCKED) && (sync_4x != (phase == 2'd3));
    assign next_phase = phase + 2'd1;

    always_comb begin
        next_nib = hold_io[3:0];
        next_oe  = hold_oe[0];
        next_clk = hold_clk[0];
        case (next_phase)
            2'd1: begin
                next_nib = hold_io[11:8];
                next_oe  = hold_oe[2];
                next_clk = hold_clk[2];
            end
            2'd2: begin
                next_nib = hold_io[7:4];
                next_oe  = hold_oe[1];
                next_clk = hold_clk[1];
            end
            default: begin
                next_nib = hold_io[3:0];
                next_oe  = hold_oe[0];
                next_clk = hold_clk[0];
            end
        endcase
    end

    always_ff @(posedge clk_4x_s) begin
        if (rst) begin
            state     <= ST_UNLOCK;
            phase     <= 2'd0;
            hold_io   <= '0;
            hold_oe   <= '0;
            hold_clk  <= '0;
            hold_cs   <= 1'b0;
            rx_asm    <= '0;
            phy_io_i  <= '0;
            pad_io_o  <= '0;
            pad_io_oe <= 1'b0;
            pad_clk   <= IDLE_CLK;
            pad_cs_n  <= 1'b1;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
            for (int i = 0; i <= RD_DELAY; i++) begin
                rx_pipe[i] <= '0;
            end
        end else begin
            sync_err   <= 1'b0;
            rx_pipe[0] <= pad_io_i;
            for (int i = 1; i <= RD_DELAY; i++) begin
                rx_pipe[i] <= rx_pipe[i-1];
            end
            rx_asm <= {rx_asm[11:0], rx_pipe[RD_DELAY]};

            if ((state == ST_UNLOCK && sync_4x) || load_edge) begin
                state     <= ST_LOCKED;
                locked    <= 1'b1;
                phase     <= 2'd0;
                hold_io   <= phy_io_o[11:0];
                hold_oe   <= phy_io_oe[2:0];
                hold_clk  <= phy_clk_o[2:0];
                hold_cs   <= phy_cs_o;
                pad_io_o  <= phy_io_o[15:12];
                pad_io_oe <= phy_io_oe[3];
                pad_clk   <= phy_clk_o[3];
                pad_cs_n  <= ~phy_cs_o;
                // The word completed in the previous period is handed over.
                if (load_edge) begin
                    phy_io_i <= rx_asm;
                end
            end else if (state == ST_UNLOCK || cad_err) begin
                state     <= ST_UNLOCK;
                locked    <= 1'b0;
                sync_err  <= cad_err;
                pad_io_o  <= '0;
                pad_io_oe <= 1'b0;
                pad_clk   <= IDLE_CLK;
                pad_cs_n  <= 1'b1;
            end else begin
                phase     <= next_phase;
                pad_io_o  <= next_nib;
                pad_io_oe <= next_oe;
                pad_clk   <= next_clk;
                pad_cs_n  <= ~hold_cs;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qpi_gearbox_4x.sv
`default_nettype none
// ============================================================================
// Module   : tb_qpi_gearbox_4x
// Purpose  : Self-checking bench for qpi_gearbox_4x against a slot-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qpi_gearbox_4x;

    localparam int RD = 4;

    logic        clk_4x_s = 1'b0;
    logic        rst = 1'b1;
    logic        sync_4x = 1'b0;
    logic [15:0] phy_io_o = '0;
    logic [3:0]  phy_io_oe = '0;
    logic [3:0]  phy_clk_o = '0;
    logic        phy_cs_o = 1'b0;
    logic [15:0] phy_io_i;
    logic [3:0]  pad_io_o;
    logic        pad_io_oe;
    logic [3:0]  pad_io_i = '0;
    logic        pad_clk;
    logic        pad_cs_n;
    logic        locked;
    logic        sync_err;

    int checks = 0;
    int errors = 0;

    qpi_gearbox_4x #(.RD_DELAY(RD), .IDLE_CLK(1'b0)) dut (
        .clk_4x_s (clk_4x_s),
        .rst      (rst),
        .sync_4x  (sync_4x),
        .phy_io_o (phy_io_o),
        .phy_io_oe(phy_io_oe),
        .phy_clk_o(phy_clk_o),
        .phy_cs_o (phy_cs_o),
        .phy_io_i (phy_io_i),
        .pad_io_o (pad_io_o),
        .pad_io_oe(pad_io_oe),
        .pad_io_i (pad_io_i),
        .pad_clk  (pad_clk),
        .pad_cs_n (pad_cs_n),
        .locked   (locked),
        .sync_err (sync_err)
    );

    always #5 clk_4x_s = ~clk_4x_s;

    // Reference model: a period is a word of 4 slots; m_slot is the slot on
    // the pads, hist[] holds the pad nibble sampled at each edge.
    int          n = 0;
    int          m_load_n = 0;
    int          m_slot = 0;
    logic        m_locked = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_word = '0;
    logic [3:0]  m_oe = '0;
    logic [3:0]  m_clk = '0;
    logic        m_cs = 1'b0;
    logic [15:0] m_phy_i = '0;
    logic [3:0]  hist [0:63];

    function automatic logic [15:0] rx_expect(input int e);
        logic [15:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            w = {w[11:0], hist[((e - 5 - RD + j) % 64 + 64) % 64]};
        end
        return w;
    endfunction

    task automatic model_edge(input logic s, input logic [15:0] w, input logic [3:0] oe,
                              input logic [3:0] ck, input logic cs, input logic [3:0] pin,
                              input logic r);
        n++;
        m_err = 1'b0;
        hist[n % 64] = pin;
        if (r) begin
            for (int i = 0; i < 64; i++) hist[i] = '0;
            m_locked = 1'b0;
            m_phy_i  = '0;
            m_slot   = 0;
        end else if ((!m_locked && s) || (m_locked && m_slot == 3 && s)) begin
            if (m_locked) m_phy_i = rx_expect(n);
            m_locked = 1'b1;
            m_slot   = 0;
            m_word   = w;
            m_oe     = oe;
            m_clk    = ck;
            m_cs     = cs;
            m_load_n = n;
        end else if (m_locked && ((m_slot == 3) != s)) begin
            m_locked = 1'b0;
            m_err    = 1'b1;
        end else if (m_locked) begin
            m_slot++;
        end
    endtask

    task automatic cycle(input logic s, input logic [15:0] w, input logic [3:0] oe,
                         input logic [3:0] ck, input logic cs, input logic [3:0] pin,
                         input logic r);
        sync_4x = s; phy_io_o = w; phy_io_oe = oe; phy_clk_o = ck;
        phy_cs_o = cs; pad_io_i = pin; rst = r;
        @(posedge clk_4x_s);
        model_edge(s, w, oe, ck, cs, pin, r);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, '0, 1'b0, 4'($urandom), 1'b1);
        checks++;
        if (locked !== 1'b0 || pad_cs_n !== 1'b1 || pad_io_oe !== 1'b0 || pad_clk !== 1'b0 ||
            phy_io_i !== 16'h0 || sync_err !== 1'b0 || pad_io_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_values: got locked=%b cs_n=%b oe=%b clk=%b phy_i=%h err=%b io=%h",
                     locked, pad_cs_n, pad_io_oe, pad_clk, phy_io_i, sync_err, pad_io_o);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 16'($urandom), 4'hF, 4'hF, 1'b1, 4'($urandom), 1'b0);
            checks++;
            if (locked !== 1'b0 || pad_cs_n !== 1'b1 || pad_io_oe !== 1'b0) begin
                errors++;
                $display("FAIL idle_unlocked cyc %0d: got locked=%b cs_n=%b oe=%b want 0 1 0",
                         i, locked, pad_cs_n, pad_io_oe);
            end
        end
    endtask

    task automatic test_tx_order;
        logic [15:0] w;
        w = 16'hA5C3;
        for (int k = 0; k < 12; k++) begin
            cycle(k % 4 == 0, w, 4'hF, 4'h0, 1'b1, '0, 1'b0);
            checks++;
            if (pad_io_o !== w[15 - 4 * (k % 4) -: 4] || pad_cs_n !== 1'b0 ||
                locked !== 1'b1 || pad_io_oe !== 1'b1) begin
                errors++;
                $display("FAIL tx_order k=%0d: got io=%h cs_n=%b locked=%b oe=%b want io=%h 0 1 1",
                         k, pad_io_o, pad_cs_n, locked, pad_io_oe, w[15 - 4 * (k % 4) -: 4]);
            end
        end
    endtask

    task automatic test_clk_oe;
        logic [3:0] exp_clk;
        logic [3:0] exp_oe;
        exp_clk = 4'b0101;
        exp_oe  = 4'b1100;
        for (int k = 0; k < 8; k++) begin
            cycle(k % 4 == 0, 16'($urandom), 4'b1100, 4'b0101, 1'b1, '0, 1'b0);
            checks++;
            if (pad_clk !== exp_clk[3 - k % 4] || pad_io_oe !== exp_oe[3 - k % 4]) begin
                errors++;
                $display("FAIL clk_oe slot %0d: got clk=%b oe=%b want clk=%b oe=%b",
                         k % 4, pad_clk, pad_io_oe, exp_clk[3 - k % 4], exp_oe[3 - k % 4]);
            end
        end
    endtask

    task automatic test_rx_align;
        logic [3:0] pin;
        for (int k = 0; k < 20; k++) begin
            pin = 4'((((n + 1 - m_load_n + 1) & 3) + 1));
            cycle(k % 4 == 0, 16'($urandom), 4'h0, 4'h0, 1'b1, pin, 1'b0);
            if (k >= 12) begin
                checks++;
                if (phy_io_i !== 16'h1234) begin
                    errors++;
                    $display("FAIL rx_align k=%0d: got %h want 1234", k, phy_io_i);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] w;
        logic [3:0]  oe, ck;
        logic        cs;
        for (int k = 0; k < 160; k++) begin
            if (k % 4 == 0) begin
                w = 16'($urandom); oe = 4'($urandom); ck = 4'($urandom); cs = 1'($urandom);
            end
            cycle(k % 4 == 0, w, oe, ck, cs, 4'($urandom), 1'b0);
            checks++;
            if (locked !== m_locked || sync_err !== m_err || phy_io_i !== m_phy_i ||
                pad_io_o !== m_word[15 - 4 * m_slot -: 4] || pad_io_oe !== m_oe[3 - m_slot] ||
                pad_clk !== m_clk[3 - m_slot] || pad_cs_n !== ~m_cs) begin
                errors++;
                $display("FAIL random k=%0d: got lk=%b io=%h oe=%b clk=%b csn=%b phy_i=%h want lk=%b io=%h oe=%b clk=%b csn=%b phy_i=%h",
                         k, locked, pad_io_o, pad_io_oe, pad_clk, pad_cs_n, phy_io_i, m_locked,
                         m_word[15 - 4 * m_slot -: 4], m_oe[3 - m_slot], m_clk[3 - m_slot], ~m_cs, m_phy_i);
            end
        end
    endtask

    task automatic test_cadence;
        // Early sync: load, slot1, slot2, then sync one cycle too soon.
        cycle(1'b1, 16'hFFFF, 4'hF, 4'hF, 1'b1, '0, 1'b0);
        cycle(1'b0, 16'hFFFF, 4'hF, 4'hF, 1'b1, '0, 1'b0);
        cycle(1'b0, 16'hFFFF, 4'hF, 4'hF, 1'b1, '0, 1'b0);
        cycle(1'b1, 16'hFFFF, 4'hF, 4'hF, 1'b1, '0, 1'b0);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || pad_io_oe !== 1'b0 ||
            pad_cs_n !== 1'b1 || pad_clk !== 1'b0) begin
            errors++;
            $display("FAIL early_sync: got err=%b lk=%b oe=%b csn=%b clk=%b want 1 0 0 1 0",
                     sync_err, locked, pad_io_oe, pad_cs_n, pad_clk);
        end
        cycle(1'b0, 16'hFFFF, 4'hF, 4'hF, 1'b1, '0, 1'b0);
        checks++;
        if (sync_err !== 1'b0 || locked !== 1'b0 || pad_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse_len: got err=%b lk=%b csn=%b want 0 0 1", sync_err, locked, pad_cs_n);
        end
        cycle(1'b0, 16'hFFFF, 4'hF, 4'hF, 1'b1, '0, 1'b0);
        cycle(1'b1, 16'h9FFF, 4'hF, 4'hF, 1'b1, '0, 1'b0);
        checks++;
        if (locked !== 1'b1 || pad_cs_n !== 1'b0 || pad_io_o !== 4'h9) begin
            errors++;
            $display("FAIL relock: got lk=%b csn=%b io=%h want 1 0 9", locked, pad_cs_n, pad_io_o);
        end
        // Missing sync after slot 3.
        for (int k = 0; k < 4; k++) cycle(1'b0, 16'hFFFF, 4'hF, 4'hF, 1'b1, '0, 1'b0);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || pad_io_oe !== 1'b0) begin
            errors++;
            $display("FAIL missing_sync: got err=%b lk=%b oe=%b want 1 0 0", sync_err, locked, pad_io_oe);
        end
    endtask

    task automatic test_rst_mid;
        for (int k = 0; k < 16; k++)
            cycle(k % 4 == 0, 16'($urandom), 4'hF, 4'h0, 1'b1, 4'($urandom_range(1, 15)), 1'b0);
        checks++;
        if (phy_io_i !== m_phy_i) begin
            errors++;
            $display("FAIL pre_rst_word: got %h want %h", phy_io_i, m_phy_i);
        end
        cycle(1'b1, 16'h1234, 4'hF, 4'h0, 1'b1, 4'h7, 1'b0);
        cycle(1'b0, 16'h1234, 4'hF, 4'h0, 1'b1, 4'h7, 1'b0);
        cycle(1'b0, 16'h1234, 4'hF, 4'h0, 1'b1, 4'h7, 1'b0);
        cycle(1'b0, 16'h1234, 4'hF, 4'h0, 1'b1, 4'h7, 1'b1);
        checks++;
        if (pad_cs_n !== 1'b1 || pad_io_oe !== 1'b0 || phy_io_i !== 16'h0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got csn=%b oe=%b phy_i=%h lk=%b want 1 0 0000 0",
                     pad_cs_n, pad_io_oe, phy_io_i, locked);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) hist[i] = '0;
        test_reset;
        test_tx_order;
        test_clk_oe;
        test_rx_align;
        test_random;
        test_cadence;
        test_rst_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
